arm_mac_iter: RTL and testbench

- Iterative multiply-accumulate unit for arm_core; executes the ARM MUL, MLA, UMULL, UMLAL, SMULL and SMLAL operations.
- Multi-cycle, with a start/busy/done handshake. The core stalls while busy is high.
- Radix is parametrised: BITS_PER_CYCLE multiplier bits are retired per cycle.
- Produces a 2*WIDTH result and N/Z flags for the CPSR.

---
 rtl/arm_mac_iter_if.sv | 27 ++
 rtl/arm_mac_iter.sv | 170 +++++++++++++++++
 tb/tb_arm_mac_iter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mac_iter_if.sv
// Handshake and operand/result bundle between the core and the iterative MAC unit.
interface arm_mac_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] acc_hi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             n_flag;
    logic             z_flag;

    modport master (
        output start, op, rm, rs, acc_lo, acc_hi,
        input  busy, done, result_lo, result_hi, n_flag, z_flag
    );

    modport slave (
        input  start, op, rm, rs, acc_lo, acc_hi,
        output busy, done, result_lo, result_hi, n_flag, z_flag
    );
endinterface

// File: rtl/arm_mac_iter.sv
// Iterative multiply-accumulate unit for arm_core: MUL, MLA, UMULL, UMLAL, SMULL, SMLAL.
// Retires BITS_PER_CYCLE multiplier bits per cycle on magnitudes, negates at the end for
// signed ops, then accumulates and produces N/Z.
// Optional build macro ARM_MAC_EARLY_TERM_EN: leave the multiply loop as soon as the
// remaining multiplier bits are all zero (data-dependent latency, identical results).
module arm_mac_iter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input logic           clk,
    input logic           rst,
    arm_mac_iter_if.slave bus
);
    localparam int unsigned Iters = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW  = $clog2(Iters + 1);
    localparam int unsigned ShW   = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {StIdle, StMult, StAcc, StDone} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [WIDTH-1:0]         mcand_q, mcand_d;
    logic [WIDTH-1:0]         mplier_q, mplier_d;
    logic                     sign_q, sign_d;
    logic [2*WIDTH-1:0]       acc_q, acc_d;
    logic [2*WIDTH-1:0]       partial_q, partial_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]         res_lo_q, res_lo_d;
    logic [WIDTH-1:0]         res_hi_q, res_hi_d;
    logic                     n_q, n_d;
    logic                     z_q, z_d;

    // Operand conditioning at launch
    logic                     in_signed;
    logic [WIDTH-1:0]         rm_abs, rs_abs;

    assign in_signed = bus.op[2] & bus.op[1];
    assign rm_abs    = (in_signed && bus.rm[WIDTH-1]) ? -bus.rm : bus.rm;
    assign rs_abs    = (in_signed && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;

    // One radix step: digit partial product placed at its bit position
    logic [BITS_PER_CYCLE-1:0]       digit;
    logic [WIDTH+BITS_PER_CYCLE-1:0] pp;
    logic [ShW-1:0]                  shamt;
    logic [2*WIDTH-1:0]              addend;
    logic [WIDTH-1:0]                mplier_nxt;
    logic                            mult_last;

    assign digit      = mplier_q[BITS_PER_CYCLE-1:0];
    assign pp         = {{BITS_PER_CYCLE{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, digit};
    assign shamt      = ShW'(cnt_q) * ShW'(BITS_PER_CYCLE);
    assign addend     = {{(WIDTH-BITS_PER_CYCLE){1'b0}}, pp} << shamt;
    assign mplier_nxt = mplier_q >> BITS_PER_CYCLE;

`ifdef ARM_MAC_EARLY_TERM_EN
    // Exit once no set bits remain beyond the digit added this cycle; a zero multiplier
    // still spends one cycle adding zero, so MULT lasts max(1, ceil(bitlen/radix)).
    assign mult_last = (cnt_q == CntW'(Iters - 1)) || (mplier_nxt == '0);
`else
    assign mult_last = (cnt_q == CntW'(Iters - 1));
`endif

    // Final sign fix-up and accumulate
    logic                     is_long, is_mla, long_acc;
    logic [2*WIDTH-1:0]       prod, sum_long;
    logic [WIDTH-1:0]         sum_short;

    assign is_long   = op_q[2];
    assign is_mla    = (op_q == 3'b001);
    assign long_acc  = op_q[2] & op_q[0];
    assign prod      = sign_q ? -partial_q : partial_q;
    assign sum_long  = prod + (long_acc ? acc_q : '0);
    assign sum_short = prod[WIDTH-1:0] + (is_mla ? acc_q[WIDTH-1:0] : '0);

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        n_d       = n_q;
        z_d       = z_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    mcand_d   = rm_abs;
                    mplier_d  = rs_abs;
                    sign_d    = in_signed & (bus.rm[WIDTH-1] ^ bus.rs[WIDTH-1]);
                    acc_d     = {bus.acc_hi, bus.acc_lo};
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = StMult;
                end
            end
            StMult: begin
                partial_d = partial_q + addend;
                mplier_d  = mplier_nxt;
                cnt_d     = cnt_q + 1'b1;
                if (mult_last) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (is_long) begin
                    res_lo_d = sum_long[WIDTH-1:0];
                    res_hi_d = sum_long[2*WIDTH-1:WIDTH];
                    n_d      = sum_long[2*WIDTH-1];
                    z_d      = (sum_long == '0);
                end else begin
                    res_lo_d = sum_short;
                    res_hi_d = '0;
                    n_d      = sum_short[WIDTH-1];
                    z_d      = (sum_short == '0);
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sign_q    <= 1'b0;
            acc_q     <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sign_q    <= sign_d;
            acc_q     <= acc_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            n_q       <= n_d;
            z_q       <= z_d;
        end
    end

    assign bus.busy      = (state_q == StMult) || (state_q == StAcc);
    assign bus.done      = (state_q == StDone);
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.n_flag    = n_q;
    assign bus.z_flag    = z_q;
endmodule

// File: tb/tb_arm_mac_iter.sv
// Self-checking bench for arm_mac_iter: vector table, random ops against a 64-bit model,
// plus directed busy/done timing, start-while-busy, start-in-DONE and mid-op reset.
module tb_arm_mac_iter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned BPC   = 2;
    localparam int unsigned K     = WIDTH / BPC;
`ifdef ARM_MAC_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arm_mac_iter_if #(.WIDTH(WIDTH)) bus ();

    arm_mac_iter #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] acc_lo;
        logic [31:0] acc_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic        exp_n;
        logic        exp_z;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        n;
        logic        z;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Number of MULT cycles expected for an operation
    function automatic int mult_cycles(input logic [2:0] op, input logic [31:0] rs);
        logic [31:0] a;
        int          bl;
        a  = (op[2] && op[1] && rs[31]) ? -rs : rs;
        bl = 0;
        for (int i = 0; i < 32; i++) if (a[i]) bl = i + 1;
        if (!EarlyTerm) return K;
        return (bl == 0) ? 1 : (bl + BPC - 1) / BPC;
    endfunction

    // Reference model using full 64-bit sign-extended products
    task automatic model(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] al, input logic [31:0] ah, output vec_t v);
        logic [63:0] p;
        logic [31:0] lo;
        v.op = op; v.rm = rm; v.rs = rs; v.acc_lo = al; v.acc_hi = ah;
        if (op[2]) begin
            if (op[1]) p = {{32{rm[31]}}, rm} * {{32{rs[31]}}, rs};
            else       p = {32'b0, rm} * {32'b0, rs};
            if (op[0]) p = p + {ah, al};
            v.exp_lo = p[31:0];
            v.exp_hi = p[63:32];
            v.exp_n  = p[63];
            v.exp_z  = (p == 64'd0);
        end else begin
            lo = rm * rs;
            if (op == 3'b001) lo = lo + al;
            v.exp_lo = lo;
            v.exp_hi = 32'd0;
            v.exp_n  = lo[31];
            v.exp_z  = (lo == 32'd0);
        end
    endtask

    // Scoreboard side: compare every done pulse against the oldest expectation
    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result_lo", 64'(bus.result_lo), 64'(mon_e.lo));
                check("result_hi", 64'(bus.result_hi), 64'(mon_e.hi));
                check("n_flag", 64'(bus.n_flag), 64'(mon_e.n));
                check("z_flag", 64'(bus.z_flag), 64'(mon_e.z));
                check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            end
        end
    end

    // Called at a negedge in an IDLE cycle; start is sampled at the following posedge
    task automatic launch(input vec_t v, input bit push);
        exp_t e;
        bus.start  = 1'b1;
        bus.op     = v.op;
        bus.rm     = v.rm;
        bus.rs     = v.rs;
        bus.acc_lo = v.acc_lo;
        bus.acc_hi = v.acc_hi;
        if (push) begin
            e.lo       = v.exp_lo;
            e.hi       = v.exp_hi;
            e.n        = v.exp_n;
            e.z        = v.exp_z;
            e.done_cyc = cyc + 2 + mult_cycles(v.op, v.rs);
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns just after the negedge of the DONE cycle
    task automatic wait_pop();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic wait_done();
        wait_pop();
        @(negedge clk);
    endtask

    vec_t vecs[19];
    vec_t v;
    int   c0;
    int   lat;

    initial begin
        vecs[0]  = '{3'b000, 32'd7, 32'd6, 32'd0, 32'd0, 32'd42, 32'd0, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0};
        vecs[2]  = '{3'b110, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0,
                     32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[3]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0,
                     32'd2, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[4]  = '{3'b000, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};
        vecs[5]  = '{3'b111, 32'h80000000, 32'h80000000, 32'd5, 32'd0,
                     32'd5, 32'h40000000, 1'b0, 1'b0};
        vecs[6]  = '{3'b110, 32'h80000000, 32'd1, 32'd0, 32'd0,
                     32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7]  = '{3'b100, 32'h10000, 32'h10000, 32'd0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};
        vecs[9]  = '{3'b010, 32'd3, 32'd5, 32'd100, 32'd7, 32'd15, 32'd0, 1'b0, 1'b0};
        vecs[10] = '{3'b000, 32'h10000, 32'h10000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};
        vecs[11] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'd0, 32'd0, 1'b0, 1'b1};
        vecs[12] = '{3'b000, 32'h40000000, 32'd2, 32'd0, 32'd0, 32'h80000000, 32'd0, 1'b1, 1'b0};
        vecs[13] = '{3'b110, 32'd5, 32'hFFFFFFFD, 32'd0, 32'd0,
                     32'hFFFFFFF1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[14] = '{3'b000, 32'd9, 32'd3, 32'd0, 32'd0, 32'd27, 32'd0, 1'b0, 1'b0};
        vecs[15] = '{3'b000, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0};
        vecs[16] = '{3'b100, 32'd2, 32'd3, 32'd7, 32'd9, 32'd6, 32'd0, 1'b0, 1'b0};
        vecs[17] = '{3'b011, 32'd2, 32'd3, 32'd7, 32'd9, 32'd6, 32'd0, 1'b0, 1'b0};
        vecs[18] = '{3'b110, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.rm     = 32'd0;
        bus.rs     = 32'd0;
        bus.acc_lo = 32'd0;
        bus.acc_hi = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_result_lo", 64'(bus.result_lo), 64'd0);
        check("reset_result_hi", 64'(bus.result_hi), 64'd0);
        check("reset_n", 64'(bus.n_flag), 64'd0);
        check("reset_z", 64'(bus.z_flag), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Exact busy/done window for MUL 7*6
        c0  = cyc;
        lat = mult_cycles(3'b000, 32'd6);
        launch(vecs[0], 1'b1);
        while (cyc <= c0 + lat + 3) begin
            check("busy_window", 64'(bus.busy), 64'(cyc >= c0 + 1 && cyc <= c0 + lat + 1));
            check("done_window", 64'(bus.done), 64'(cyc == c0 + lat + 2));
            @(negedge clk);
        end
        wait_done();

        for (int i = 0; i < 19; i++) begin
            launch(vecs[i], 1'b1);
            wait_done();
        end

        for (int i = 0; i < 10; i++) begin
            logic [31:0] rs_r;
            rs_r = $urandom();
            if (i % 3 == 0) rs_r = rs_r >> $urandom_range(4, 31);
            model(3'($urandom_range(0, 7)), $urandom(), rs_r, $urandom(), $urandom(), v);
            launch(v, 1'b1);
            wait_done();
        end

        // Start during busy is ignored and changed operands do not leak in
        c0 = cyc;
        model(3'b100, 32'h12345678, 32'd9, 32'd0, 32'd0, v);
        launch(v, 1'b1);
        while (cyc < c0 + 5) @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 3'b000;
        bus.rm     = 32'd1;
        bus.rs     = 32'd1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rm     = 32'hDEADBEEF;
        bus.rs     = 32'hCAFEF00D;
        wait_done();
        repeat (25) @(negedge clk);
        check("busy_start_kept_lo", 64'(bus.result_lo), 64'h00000000A3D70A38);

        // Start during the DONE cycle is ignored
        model(3'b100, 32'd3, 32'd4, 32'd0, 32'd0, v);
        launch(v, 1'b1);
        wait_pop();
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.rm    = 32'd1;
        bus.rs    = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        check("done_start_kept_lo", 64'(bus.result_lo), 64'd12);
        check("done_start_idle", 64'(bus.busy), 64'd0);

        // Mid-operation reset: no done, outputs cleared, then a clean run
        c0 = cyc;
        model(3'b110, 32'd100, 32'd200, 32'd0, 32'd0, v);
        launch(v, 1'b0);
        while (cyc < c0 + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_result_lo", 64'(bus.result_lo), 64'd0);
        check("midrst_result_hi", 64'(bus.result_hi), 64'd0);
        check("midrst_n", 64'(bus.n_flag), 64'd0);
        check("midrst_z", 64'(bus.z_flag), 64'd0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        model(3'b001, 32'd10, 32'd10, 32'd5, 32'd0, v);
        launch(v, 1'b1);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
